// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and constants for the CPU run monitor.
package cpu_run_monitor_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRst,
      StRun,
      StDone
   } state_e;

   typedef enum logic [2:0] {
      StatusNone     = 3'd0,
      StatusSyscall  = 3'd1,
      StatusEndPc    = 3'd2,
      StatusSelfLoop = 3'd3,
      StatusTimeout  = 3'd4
   } status_e;

   localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;

endpackage

// File: rtl/pc_trace_buffer.sv
// Ring buffer of recently executed PCs; index 0 reads the most recent push.
module pc_trace_buffer #(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned TRACE_DEPTH = 8
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           clear_i,
   input  logic                           push_i,
   input  logic [PC_WIDTH-1:0]            din_i,
   input  logic [$clog2(TRACE_DEPTH)-1:0] idx_i,
   output logic [PC_WIDTH-1:0]            dout_o
);

   localparam int unsigned IdxW = $clog2(TRACE_DEPTH);

   logic [PC_WIDTH-1:0] mem_q [TRACE_DEPTH];
   logic [IdxW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [IdxW:0]       fill_q, fill_d;
   logic [IdxW-1:0]     rd_ptr;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         fill_d   = '0;
      end else if (push_i) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (fill_q != (IdxW + 1)'(TRACE_DEPTH)) begin
            fill_d = fill_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
      end
   end

   // Storage is not reset; the fill count masks stale entries on read.
   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_comb begin
      rd_ptr = wr_ptr_q - 1'b1 - idx_i;
      dout_o = ({1'b0, idx_i} < fill_q) ? mem_q[rd_ptr] : '0;
   end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller for the single-cycle CPU: sequences its reset, counts RUN cycles,
// detects halt conditions and records a trace of executed PCs.
module cpu_run_monitor
   import cpu_run_monitor_pkg::*;
#(
   parameter int unsigned PC_WIDTH     = 32,
   parameter int unsigned RESET_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 1024,
   parameter int unsigned SELF_LOOP    = 4,
   parameter int unsigned TRACE_DEPTH  = 8,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           start_i,
   input  logic [PC_WIDTH-1:0]            end_pc_i,
   input  logic [PC_WIDTH-1:0]            pc_i,
   input  logic [31:0]                    instr_i,
   output logic                           cpu_reset_o,
   output logic                           running_o,
   output logic                           done_o,
   output logic [2:0]                     status_o,
   output logic [CNT_WIDTH-1:0]           cycle_count_o,
   input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
   output logic [PC_WIDTH-1:0]            trace_pc_o
);

   localparam int unsigned RstW = $clog2(RESET_CYCLES + 1);
   localparam int unsigned RepW = $clog2(SELF_LOOP + 1);

   state_e               state_q, state_d;
   status_e              status_q, status_d, halt_cause;
   logic [RstW-1:0]      rst_cnt_q, rst_cnt_d;
   logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d, cnt_inc;
   logic [RepW-1:0]      rep_q, rep_d, rep_inc;
   logic [PC_WIDTH-1:0]  prev_pc_q, prev_pc_d;
   logic                 have_prev_q, have_prev_d;
   logic                 cpu_reset_q, running_q, done_q;
   logic                 begin_run, pc_same, trace_clear, trace_push;

   always_comb begin
      state_d       = state_q;
      status_d      = status_q;
      rst_cnt_d     = rst_cnt_q;
      cycle_count_d = cycle_count_q;
      rep_d         = rep_q;
      prev_pc_d     = prev_pc_q;
      have_prev_d   = have_prev_q;
      halt_cause    = StatusNone;
      begin_run     = 1'b0;
      trace_push    = 1'b0;
      cnt_inc       = cycle_count_q + 1'b1;
      rep_inc       = rep_q + 1'b1;
      pc_same       = have_prev_q && (pc_i == prev_pc_q);

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               begin_run = 1'b1;
            end
         end
         StRst: begin
            if (rst_cnt_q == RstW'(RESET_CYCLES - 1)) begin
               state_d = StRun;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         StRun: begin
            cycle_count_d = cnt_inc;
            trace_push    = 1'b1;
            prev_pc_d     = pc_i;
            have_prev_d   = 1'b1;
            rep_d         = pc_same ? rep_inc : '0;
            if (instr_i == SYSCALL_INSTR) begin
               halt_cause = StatusSyscall;
            end else if (pc_i == end_pc_i) begin
               halt_cause = StatusEndPc;
            end else if (pc_same && (rep_inc == RepW'(SELF_LOOP))) begin
               halt_cause = StatusSelfLoop;
            end else if (cnt_inc == CNT_WIDTH'(TIMEOUT)) begin
               halt_cause = StatusTimeout;
            end
            // A halt takes the transition, so a coincident start is dropped.
            if (halt_cause != StatusNone) begin
               status_d = halt_cause;
               state_d  = StDone;
            end
         end
         StDone: begin
            if (start_i) begin
               begin_run = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (begin_run) begin
         state_d       = StRst;
         rst_cnt_d     = '0;
         cycle_count_d = '0;
         status_d      = StatusNone;
         rep_d         = '0;
         have_prev_d   = 1'b0;
      end
      trace_clear = begin_run;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= StIdle;
         status_q      <= StatusNone;
         rst_cnt_q     <= '0;
         cycle_count_q <= '0;
         rep_q         <= '0;
         prev_pc_q     <= '0;
         have_prev_q   <= 1'b0;
         cpu_reset_q   <= 1'b1;
         running_q     <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         status_q      <= status_d;
         rst_cnt_q     <= rst_cnt_d;
         cycle_count_q <= cycle_count_d;
         rep_q         <= rep_d;
         prev_pc_q     <= prev_pc_d;
         have_prev_q   <= have_prev_d;
         cpu_reset_q   <= (state_d != StRun);
         running_q     <= (state_d == StRun);
         done_q        <= (state_d == StDone);
      end
   end

   pc_trace_buffer #(
      .PC_WIDTH    (PC_WIDTH),
      .TRACE_DEPTH (TRACE_DEPTH)
   ) u_trace (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (trace_clear),
      .push_i  (trace_push),
      .din_i   (pc_i),
      .idx_i   (trace_idx_i),
      .dout_o  (trace_pc_o)
   );

   assign cpu_reset_o   = cpu_reset_q;
   assign running_o     = running_q;
   assign done_o        = done_q;
   assign status_o      = status_q;
   assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor; TIMEOUT is shortened so the timeout run stays brief.
module tb_cpu_run_monitor;

   logic        clk_i = 1'b0;
   logic        reset_i, start_i;
   logic [31:0] end_pc_i, pc_i, instr_i;
   logic        cpu_reset_o, running_o, done_o;
   logic [2:0]  status_o;
   logic [15:0] cycle_count_o;
   logic [2:0]  trace_idx_i;
   logic [31:0] trace_pc_o;

   int n_checks = 0;
   int n_fail   = 0;
   int low_cycles;

   cpu_run_monitor #(
      .PC_WIDTH     (32),
      .RESET_CYCLES (2),
      .TIMEOUT      (16),
      .SELF_LOOP    (4),
      .TRACE_DEPTH  (8),
      .CNT_WIDTH    (16)
   ) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .start_i       (start_i),
      .end_pc_i      (end_pc_i),
      .pc_i          (pc_i),
      .instr_i       (instr_i),
      .cpu_reset_o   (cpu_reset_o),
      .running_o     (running_o),
      .done_o        (done_o),
      .status_o      (status_o),
      .cycle_count_o (cycle_count_o),
      .trace_idx_i   (trace_idx_i),
      .trace_pc_o    (trace_pc_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic feed(input logic [31:0] pc, input logic [31:0] ins);
      pc_i    = pc;
      instr_i = ins;
      if (cpu_reset_o == 1'b0) low_cycles++;
      step();
   endtask

   task automatic read_trace(input string tag, input logic [2:0] idx, input logic [31:0] exp);
      trace_idx_i = idx;
      #1;
      check_eq(tag, trace_pc_o, exp);
   endtask

   // Pulses start and checks the two RST cycles before RUN begins.
   task automatic start_run(input string tag);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check_eq({tag, "_rst_count"}, cycle_count_o, 0);
      check_eq({tag, "_rst_status"}, status_o, 0);
      check_eq({tag, "_rst_cpu_reset"}, cpu_reset_o, 1);
      check_eq({tag, "_rst_done"}, done_o, 0);
      read_trace({tag, "_rst_trace_empty"}, 3'd0, 32'h0);
      step();
      check_eq({tag, "_rst2_running"}, running_o, 0);
      step();
      check_eq({tag, "_run_running"}, running_o, 1);
      check_eq({tag, "_run_cpu_reset"}, cpu_reset_o, 0);
      low_cycles = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset_i     = 1'b1;
      start_i     = 1'b0;
      end_pc_i    = '0;
      pc_i        = '0;
      instr_i     = '0;
      trace_idx_i = '0;
      step();
      step();
      reset_i = 1'b0;
      step();
      check_eq("reset_cpu_reset", cpu_reset_o, 1);
      check_eq("reset_running", running_o, 0);
      check_eq("reset_done", done_o, 0);
      check_eq("reset_status", status_o, 0);
      check_eq("reset_count", cycle_count_o, 0);
      read_trace("reset_trace", 3'd0, 32'h0);

      // end_pc halt on a 0,4,8 ramp
      end_pc_i = 32'h8;
      start_run("t1");
      feed(32'h0, 32'h0);
      check_eq("t1_running_c1", running_o, 1);
      check_eq("t1_count_c1", cycle_count_o, 1);
      feed(32'h4, 32'h0);
      feed(32'h8, 32'h0);
      check_eq("t1_done", done_o, 1);
      check_eq("t1_cpu_reset", cpu_reset_o, 1);
      check_eq("t1_running", running_o, 0);
      check_eq("t1_status", status_o, 2);
      check_eq("t1_count", cycle_count_o, 3);
      check_eq("t1_low_cycles", low_cycles, 3);
      step();
      check_eq("t1_hold_done", done_o, 1);
      check_eq("t1_hold_count", cycle_count_o, 3);
      read_trace("t1_trace0", 3'd0, 32'h8);
      read_trace("t1_trace1", 3'd1, 32'h4);
      read_trace("t1_trace2", 3'd2, 32'h0);

      // restart from DONE; syscall coincides with end_pc and must win
      end_pc_i = 32'h44;
      start_run("t2");
      feed(32'h40, 32'h0);
      feed(32'h44, 32'h0000_000C);
      check_eq("t2_done", done_o, 1);
      check_eq("t2_status", status_o, 1);
      check_eq("t2_count", cycle_count_o, 2);
      read_trace("t2_trace0", 3'd0, 32'h44);
      read_trace("t2_trace1", 3'd1, 32'h40);
      read_trace("t2_trace2_unfilled", 3'd2, 32'h0);

      // self-loop: 0, 4, then 4 held; start coincides with the halting cycle
      end_pc_i = 32'hFFFF_FFF0;
      start_run("t3");
      feed(32'h0, 32'h0);
      feed(32'h4, 32'h0);
      feed(32'h4, 32'h0);
      feed(32'h4, 32'h0);
      feed(32'h4, 32'h0);
      check_eq("t3_running_before_halt", running_o, 1);
      check_eq("t3_done_before_halt", done_o, 0);
      start_i = 1'b1;
      feed(32'h4, 32'h0);
      start_i = 1'b0;
      check_eq("t3_done", done_o, 1);
      check_eq("t3_status", status_o, 3);
      check_eq("t3_count", cycle_count_o, 6);
      step();
      check_eq("t3_start_dropped_done", done_o, 1);
      check_eq("t3_start_dropped_cpu_reset", cpu_reset_o, 1);

      // timeout at 16 cycles; a start pulse mid-run is ignored
      start_run("t4");
      for (int k = 1; k <= 16; k++) begin
         if (k == 5) start_i = 1'b1;
         feed(32'h100 + 32'(4 * (k - 1)), 32'h0);
         start_i = 1'b0;
         if (k == 5) check_eq("t4_start_ignored", running_o, 1);
         if (k == 15) begin
            check_eq("t4_running_c15", running_o, 1);
            check_eq("t4_done_c15", done_o, 0);
         end
      end
      check_eq("t4_done", done_o, 1);
      check_eq("t4_status", status_o, 4);
      check_eq("t4_count", cycle_count_o, 16);
      for (int i = 0; i < 8; i++) begin
         read_trace($sformatf("t4_trace%0d", i), 3'(i), 32'h100 + 32'(4 * (15 - i)));
      end

      // reset in the third RUN cycle, together with start
      start_run("t5");
      feed(32'h0, 32'h0);
      feed(32'h4, 32'h0);
      pc_i    = 32'h8;
      reset_i = 1'b1;
      start_i = 1'b1;
      step();
      reset_i = 1'b0;
      start_i = 1'b0;
      check_eq("t5_cpu_reset", cpu_reset_o, 1);
      check_eq("t5_running", running_o, 0);
      check_eq("t5_done", done_o, 0);
      check_eq("t5_count", cycle_count_o, 0);
      check_eq("t5_status", status_o, 0);
      read_trace("t5_trace_empty", 3'd0, 32'h0);
      step();
      step();
      step();
      check_eq("t5_stays_idle", running_o, 0);
      check_eq("t5_stays_idle_cpu_reset", cpu_reset_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
